inert_sensor_serf: RTL and testbench
====================================

// Module: inert_sensor_serf
// PURPOSE
//  SPI responder (serf) modelling the inertial sensor at the far end of the
//  inertial-interface SPI master. Decodes 16-bit frames for register reads and
//  writes, and produces a periodic data set on the data registers.
//  Drives INT when new data is ready. Used as the sensor stand-in in
//  inertial-interface benches and in FPGA loop-back builds.
// PARAMETERS
//  DATA_PERIOD   1024    clk cycles between data-set updates (>=2)
//  WHO_AM_I_VAL  8'h6A   value returned from address 0x0F
// PORTS
//  clk    in   1  system clock
//  rst_n  in   1  asynchronous, active-low reset
//  SS_n   in   1  serf select from master, active low
//  SCLK   in   1  SPI clock from master, idles high
//  MOSI   in   1  master-out data
//  MISO   out  1  serf-out data; high-Z while SS_n high
//  INT    out  1  data-ready interrupt, active high
// BEHAVIOUR
//  Reset: all regs 0, sample_cnt=0, data_rdy=0, INT=0, MISO high-Z.
//  Sync: SS_n, SCLK, MOSI each pass through a double-flop (SS_n, SCLK preset 1).
//  - A third flop gives rise/fall detect on the synced signals.
//  Frame: SS_n fall clears the rise counter (0..16).
//  - On each synced SCLK rise: shft <= {shft[14:0],MOSI_s}; cnt++.
//  - MISO = shft[15] while SS_n_s low.
//  - Frame bits [15]=R/W (1=read), [14:8]=addr, [7:0]=data.
//  Read: the cycle after rise 8 with shft[7]=1, load shft[15:8] <= reg[shft[6:0]].
//  - The master then samples data[7:0] MSB-first on rises 9..16.
//  Write: on SS_n_s rise with cnt==16 and shft[15]=0, reg[shft[14:8]] <= shft[7:0].
//  - Writes to read-only or unmapped addresses are ignored.
//  Aborted frame: SS_n rise with cnt!=16 causes no write and no data_rdy clear.
//  - An early SS_n rise returns to idle; no error flag.
//  Map: 0x0D INT1_CTRL RW; 0x0F WHO_AM_I RO.
//  - 0x10 CTRL1_XL RW; 0x11 CTRL2_G RW.
//  - 0x22..0x2D data RO, value = (addr + sample_cnt) mod 256.
//  - Unmapped reads return 8'h00.
//  Data gen: the timer runs only while CTRL1_XL!=0 or CTRL2_G!=0.
//  - At DATA_PERIOD-1 the timer wraps; sample_cnt++ and data_rdy <= 1.
//  - Atomicity: an update falling while SS_n low is deferred to SS_n rise.
//  - A read frame always sees one consistent sample_cnt.
//  - sample_cnt wraps 8'hFF->8'h00.
//  INT = data_rdy & INT1_CTRL[1], registered, 1-cycle latency.
//  - data_rdy clears on completion (SS_n rise, cnt==16) of a read of 0x22..0x2D.
//  - Set and clear in the same cycle: set wins.
//  Reset mid-frame: immediate return to reset state; the frame is lost.
// STRUCTURE
//  Package inert_serf_pkg holds:
//  - address localparams (INT1_CTRL, WHO_AM_I, CTRL1_XL, CTRL2_G, DATA_FIRST=0x22, DATA_LAST=0x2D);
//  - FRAME_W=16 and the state enum {IDLE, SHIFT}.
//  Sub-module spi_serf_phy: sync flops, edge detect, shift reg, rise counter, MISO tri-state.
//  - It reports cmd_valid (after rise 8), frame_done (good SS_n rise) and the shift contents.
//  Top level: register file, data timer, read-load mux, data_rdy/INT logic.
// TESTING
//  1. Read 0x0F (frame 16'h8F00) -> MISO byte 8'h6A; INT stays 0.
//  2. Write 0x0D=0x02, then 0x10=0x60, then read 0x0D -> 8'h02.
//     -> After DATA_PERIOD+~3 clks INT=1.
//  3. With INT=1, read 0x22 -> returns 8'h23 (sample_cnt=1).
//     -> INT drops within 2 clks after the SS_n rise.
//  4. Drop SS_n high after 10 rises during a write to 0x11=0xFF.
//     -> 0x11 reads 8'h00 and the following frame decodes correctly.
//  5. Timer wraps while a data read is in progress -> read returns the old sample.
//     -> sample_cnt increments at the SS_n rise; INT asserts afterwards.
//  6. Pulse rst_n low at rise 5 of a frame -> MISO high-Z, INT=0, all registers 0.
//     -> The next full frame works.

Source files
------------

// File: rtl/inert_serf_pkg.sv
// Shared constants for the inertial-sensor SPI stand-in: frame geometry,
// register addresses and the frame FSM state type.
package inert_serf_pkg;

    localparam int FRAME_W = 16;
    localparam int CNT_W   = 5;

    localparam logic [6:0] INT1_CTRL  = 7'h0D;
    localparam logic [6:0] WHO_AM_I   = 7'h0F;
    localparam logic [6:0] CTRL1_XL   = 7'h10;
    localparam logic [6:0] CTRL2_G    = 7'h11;
    localparam logic [6:0] DATA_FIRST = 7'h22;
    localparam logic [6:0] DATA_LAST  = 7'h2D;

    typedef enum logic {IDLE, SHIFT} state_t;

    function automatic logic is_data_addr(input logic [6:0] addr);
        return (addr >= DATA_FIRST) && (addr <= DATA_LAST);
    endfunction

endpackage

// File: rtl/inert_sensor_serf_if.sv
// SPI bus between the inertial-interface master and the sensor, plus the INT line.
// MISO stays a plain port on the sensor because it is released to high-Z.
interface inert_sensor_serf_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic INT;

    modport master (output SS_n, output SCLK, output MOSI, input INT);
    modport slave  (input SS_n, input SCLK, input MOSI, output INT);
endinterface

// File: rtl/spi_serf_phy.sv
// SPI responder front end: synchronisers, edge detect, 16-bit shift register and rise counter.
// cmd_vld pulses one clk after the 8th synced SCLK rise; no backpressure, the master paces everything.
module spi_serf_phy
    import inert_serf_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ss_n,
    input  logic               sclk,
    input  logic               mosi,
    input  logic               load_vld,
    input  logic [7:0]         load_dat,
    output logic               cmd_vld,
    output logic               frame_done,
    output logic               ss_active,
    output logic [FRAME_W-1:0] shft_dat,
    output logic               miso_dat,
    output logic               miso_oe
);

    logic [2:0]       ss_sync;
    logic [2:0]       sclk_sync;
    logic [1:0]       mosi_sync;
    logic [CNT_W-1:0] cnt;
    state_t           state;
    state_t           state_nxt;
    logic             sclk_rise;
    logic             ss_fall;
    logic             ss_rise;
    logic             shift_en;

    // Bit 1 is the synchronised level, bit 2 the previous one for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= 3'b111;
            sclk_sync <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            ss_sync   <= {ss_sync[1:0], ss_n};
            sclk_sync <= {sclk_sync[1:0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign ss_fall   = ~ss_sync[1] & ss_sync[2];
    assign ss_rise   = ss_sync[1] & ~ss_sync[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = SHIFT;
            SHIFT:   if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shift_en   = 1'b0;
        frame_done = 1'b0;
        if (state == SHIFT) begin
            shift_en   = sclk_rise && (cnt != CNT_W'(FRAME_W));
            frame_done = ss_rise && (cnt == CNT_W'(FRAME_W));
        end
    end

    // The read-data load lands in the cycle after rise 8, never alongside a shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            shft_dat <= '0;
            cmd_vld  <= 1'b0;
        end else begin
            cmd_vld <= shift_en && (cnt == CNT_W'(7));
            if (ss_fall) begin
                cnt <= '0;
            end else if (shift_en) begin
                cnt      <= cnt + CNT_W'(1);
                shft_dat <= {shft_dat[FRAME_W-2:0], mosi_sync[1]};
            end else if (load_vld) begin
                shft_dat[15:8] <= load_dat;
            end
        end
    end

    assign ss_active = ~ss_sync[1];
    assign miso_oe   = ~ss_sync[1];
    assign miso_dat  = shft_dat[FRAME_W-1];

endmodule

// File: rtl/inert_sensor_serf.sv
// Inertial sensor stand-in: register file, periodic data generator, read-load mux and INT.
// Read data is loaded one clk after rise 8; INT follows data_rdy by one clk; no backpressure.
module inert_sensor_serf
    import inert_serf_pkg::*;
#(
    parameter int         DATA_PERIOD  = 1024,
    parameter logic [7:0] WHO_AM_I_VAL = 8'h6A
) (
    input  logic                clk,
    input  logic                rst_n,
    inert_sensor_serf_if.slave  spi,
    output logic                MISO
);

    localparam int TMR_W = (DATA_PERIOD > 2) ? $clog2(DATA_PERIOD) : 1;

    logic               cmd_vld;
    logic               frame_done;
    logic               ss_active;
    logic [FRAME_W-1:0] shft_dat;
    logic               miso_dat;
    logic               miso_oe;
    logic               load_vld;
    logic [7:0]         load_dat;
    logic [6:0]         cmd_addr;
    logic               fr_rd;
    logic [6:0]         fr_addr;
    logic [7:0]         fr_dat;
    logic [7:0]         int1_ctrl;
    logic [7:0]         ctrl1_xl;
    logic [7:0]         ctrl2_g;
    logic [7:0]         sample_cnt;
    logic [TMR_W-1:0]   timer;
    logic               timer_run;
    logic               tick;
    logic               upd_pend;
    logic               upd;
    logic               rd_clr;
    logic               data_rdy;
    logic               int_q;

    spi_serf_phy u_phy (
        .clk        (clk),
        .rst_n      (rst_n),
        .ss_n       (spi.SS_n),
        .sclk       (spi.SCLK),
        .mosi       (spi.MOSI),
        .load_vld   (load_vld),
        .load_dat   (load_dat),
        .cmd_vld    (cmd_vld),
        .frame_done (frame_done),
        .ss_active  (ss_active),
        .shft_dat   (shft_dat),
        .miso_dat   (miso_dat),
        .miso_oe    (miso_oe)
    );

    // At cmd_vld the low byte holds {R/W, addr}; at frame end the full frame is in place.
    assign cmd_addr = shft_dat[6:0];
    assign load_vld = cmd_vld & shft_dat[7];
    assign fr_rd    = shft_dat[15];
    assign fr_addr  = shft_dat[14:8];
    assign fr_dat   = shft_dat[7:0];

    always_comb begin
        load_dat = 8'h00;
        if (is_data_addr(cmd_addr)) begin
            load_dat = {1'b0, cmd_addr} + sample_cnt;
        end else begin
            case (cmd_addr)
                INT1_CTRL: load_dat = int1_ctrl;
                WHO_AM_I:  load_dat = WHO_AM_I_VAL;
                CTRL1_XL:  load_dat = ctrl1_xl;
                CTRL2_G:   load_dat = ctrl2_g;
                default:   load_dat = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int1_ctrl <= 8'h00;
            ctrl1_xl  <= 8'h00;
            ctrl2_g   <= 8'h00;
        end else if (frame_done && !fr_rd) begin
            case (fr_addr)
                INT1_CTRL: int1_ctrl <= fr_dat;
                CTRL1_XL:  ctrl1_xl  <= fr_dat;
                CTRL2_G:   ctrl2_g   <= fr_dat;
                default:   ;
            endcase
        end
    end

    assign timer_run = (ctrl1_xl != 8'h00) || (ctrl2_g != 8'h00);
    assign tick      = timer_run && (timer == TMR_W'(DATA_PERIOD - 1));
    // Sample updates wait for SS_n high so a frame never straddles two samples.
    assign upd       = (tick | upd_pend) & ~ss_active;
    assign rd_clr    = frame_done & fr_rd & is_data_addr(fr_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer      <= '0;
            upd_pend   <= 1'b0;
            sample_cnt <= 8'h00;
            data_rdy   <= 1'b0;
            int_q      <= 1'b0;
        end else begin
            if (tick)           timer <= '0;
            else if (timer_run) timer <= timer + TMR_W'(1);
            upd_pend <= (tick | upd_pend) & ss_active;
            if (upd) sample_cnt <= sample_cnt + 8'd1;
            if (upd)         data_rdy <= 1'b1;
            else if (rd_clr) data_rdy <= 1'b0;
            int_q <= data_rdy & int1_ctrl[1];
        end
    end

    assign spi.INT = int_q;
    assign MISO    = miso_oe ? miso_dat : 1'bz;

endmodule

// File: tb/tb_inert_sensor_serf.sv
// Directed bench for inert_sensor_serf: register table plus timed data/INT sequences.
module tb_inert_sensor_serf;

    localparam int P = 400;

    typedef struct {
        bit         rd;
        logic [6:0] addr;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    wire  miso;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ss_rise_cyc = 0;

    inert_sensor_serf_if spi ();

    inert_sensor_serf #(.DATA_PERIOD(P), .WHO_AM_I_VAL(8'h6A)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .spi   (spi),
        .MISO  (miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master side: 3-clk SCLK half periods, MISO sampled just before rises 9..16.
    task automatic spi_frame(input logic [15:0] tx, input int stop_at, input int stall_at,
                             input int stall_n, input bit hold_ss, output logic [7:0] rx);
        rx = 8'h00;
        @(negedge clk);
        spi.SS_n = 1'b0;
        idle(4);
        for (int i = 0; i < 16; i++) begin
            spi.SCLK = 1'b0;
            spi.MOSI = tx[15-i];
            idle(3);
            if (i >= 8) rx = {rx[6:0], miso};
            spi.SCLK = 1'b1;
            idle(3);
            if (i + 1 == stall_at) idle(stall_n);
            if (i + 1 == stop_at) break;
        end
        if (!hold_ss) begin
            spi.SS_n = 1'b1;
            ss_rise_cyc = cyc;
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        logic [7:0] rx;
        spi_frame({v.rd, v.addr, v.rd ? 8'h00 : v.dat}, 0, 0, 0, 1'b0, rx);
        idle(6);
        if (v.rd) check($sformatf("%s read %h", tag, v.addr), rx, v.exp);
        check($sformatf("%s INT idle", tag), {7'b0, spi.INT}, 8'h00);
    endtask

    vec_t tbl[14];
    vec_t post[7];

    initial begin
        logic [7:0] rx;
        int n0;
        bit found;

        tbl[0]  = '{1'b1, 7'h0F, 8'h00, 8'h6A};
        tbl[1]  = '{1'b0, 7'h0F, 8'h11, 8'h00};
        tbl[2]  = '{1'b1, 7'h0F, 8'h00, 8'h6A};
        tbl[3]  = '{1'b0, 7'h05, 8'h77, 8'h00};
        tbl[4]  = '{1'b1, 7'h05, 8'h00, 8'h00};
        tbl[5]  = '{1'b0, 7'h0D, 8'h02, 8'h00};
        tbl[6]  = '{1'b1, 7'h0D, 8'h00, 8'h02};
        tbl[7]  = '{1'b1, 7'h22, 8'h00, 8'h22};
        tbl[8]  = '{1'b1, 7'h2D, 8'h00, 8'h2D};
        tbl[9]  = '{1'b1, 7'h21, 8'h00, 8'h00};
        tbl[10] = '{1'b1, 7'h2E, 8'h00, 8'h00};
        tbl[11] = '{1'b0, 7'h2D, 8'h55, 8'h00};
        tbl[12] = '{1'b1, 7'h2D, 8'h00, 8'h2D};
        tbl[13] = '{1'b1, 7'h10, 8'h00, 8'h00};

        post[0] = '{1'b1, 7'h0D, 8'h00, 8'h00};
        post[1] = '{1'b1, 7'h10, 8'h00, 8'h00};
        post[2] = '{1'b1, 7'h11, 8'h00, 8'h00};
        post[3] = '{1'b1, 7'h22, 8'h00, 8'h22};
        post[4] = '{1'b1, 7'h0F, 8'h00, 8'h6A};
        post[5] = '{1'b0, 7'h0D, 8'h03, 8'h00};
        post[6] = '{1'b1, 7'h0D, 8'h00, 8'h03};

        spi.SS_n = 1'b1;
        spi.SCLK = 1'b1;
        spi.MOSI = 1'b0;
        rst_n = 1'b0;
        idle(3);
        check("reset INT", {7'b0, spi.INT}, 8'h00);
        rst_n = 1'b1;
        idle(4);

        for (int i = 0; i < 14; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Enable the accelerometer; the first sample lands P clks after the write.
        spi_frame(16'h1060, 0, 0, 0, 1'b0, rx);
        n0 = ss_rise_cyc;
        idle(6);
        spi_frame(16'h9000, 0, 0, 0, 1'b0, rx);
        check("ctrl1 readback", rx, 8'h60);
        while (cyc < n0 + P + 2) @(negedge clk);
        check("INT before period", {7'b0, spi.INT}, 8'h00);
        found = 1'b0;
        while (cyc <= n0 + P + 10 && !found) begin
            if (spi.INT) found = 1'b1;
            else @(negedge clk);
        end
        check("INT after period", {7'b0, found && (cyc <= n0 + P + 6)}, 8'h01);

        // Data read with sample_cnt=1 clears data_rdy.
        spi_frame(16'hA200, 0, 0, 0, 1'b0, rx);
        n0 = ss_rise_cyc;
        check("data 0x22 sample1", rx, 8'h23);
        check("INT held to SS rise", {7'b0, spi.INT}, 8'h01);
        while (cyc < n0 + 5) @(negedge clk);
        check("INT cleared by read", {7'b0, spi.INT}, 8'h00);
        idle(6);

        // The next sample falls inside a stalled read and must be deferred.
        spi_frame(16'hAD00, 0, 12, P, 1'b0, rx);
        n0 = ss_rise_cyc;
        check("INT deferred", {7'b0, spi.INT}, 8'h00);
        check("data 0x2D old sample", rx, 8'h2E);
        while (cyc < n0 + 6) @(negedge clk);
        check("INT after deferred", {7'b0, spi.INT}, 8'h01);
        idle(6);
        spi_frame(16'hA200, 0, 0, 0, 1'b0, rx);
        check("data 0x22 sample2", rx, 8'h24);
        idle(6);

        // Aborted write after 10 rises leaves CTRL2_G untouched.
        spi_frame(16'h11FF, 10, 0, 0, 1'b0, rx);
        idle(6);
        spi_frame(16'h9100, 0, 0, 0, 1'b0, rx);
        check("ctrl2 after abort", rx, 8'h00);
        idle(6);
        spi_frame(16'h9000, 0, 0, 0, 1'b0, rx);
        check("ctrl1 after abort", rx, 8'h60);
        idle(6);
        check("INT before reset", {7'b0, spi.INT}, 8'h01);

        // Reset mid-frame at rise 5.
        spi_frame(16'h9000, 5, 0, 0, 1'b1, rx);
        rst_n = 1'b0;
        idle(2);
        check("INT in reset", {7'b0, spi.INT}, 8'h00);
        spi.SS_n = 1'b1;
        spi.SCLK = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(6);
        check("INT after reset", {7'b0, spi.INT}, 8'h00);
        for (int i = 0; i < 7; i++) apply_vec(post[i], $sformatf("post%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
